// File: rtl/ysyx_22041071_wb_arb_if.sv
// Bus bundle for the write-back port arbiter: pipeline WB, MDU result,
// regfile write port and ID hazard/stall signals.
interface ysyx_22041071_wb_arb_if #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              pipe_w_en;
  logic [4:0]        pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              mdu_valid;
  logic [4:0]        mdu_rd;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  logic              rf_w_en;
  logic [4:0]        rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic [4:0]        chk_rs1;
  logic [4:0]        chk_rt;
  logic              pend_hit;
  logic              stall_req;
  logic [OCC_W-1:0]  occ;

  modport slave (
    input  pipe_w_en, pipe_rd, pipe_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready,
    output rf_w_en, rf_rd, rf_data,
    input  chk_rs1, chk_rt,
    output pend_hit, stall_req, occ
  );

  modport master (
    output pipe_w_en, pipe_rd, pipe_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready,
    input  rf_w_en, rf_rd, rf_data,
    output chk_rs1, chk_rt,
    input  pend_hit, stall_req, occ
  );
endinterface

// File: rtl/ysyx_22041071_wb_arb.sv
// Regfile write-port arbiter: the pipeline WB stage always wins; MDU results
// wait in an in-order queue and drain into idle slots.
module ysyx_22041071_wb_arb #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AGE_W        = 3,
  parameter int DATA_W       = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  ysyx_22041071_wb_arb_if.slave  io_bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DEPTH-1:0]  r_live;
  logic [4:0]        r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [OCC_W-1:0]  r_occ;
  logic [AGE_W-1:0]  r_age;
  logic              r_run;

  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_enq;
  logic              w_busy;
  logic              w_head_live;
  logic              w_pop_wr;
  logic              w_pop;
  logic [DEPTH-1:0]  w_kill;
  logic [DEPTH-1:0]  w_live_nxt;
  logic [AGE_W-1:0]  w_age_nxt;
  logic              w_pend;

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    if (a == AGE_W'(STARVE_LIMIT)) return a;
    else                           return a + AGE_W'(1);
  endfunction

  // readiness comes only from registered state, never from the pop decision
  assign w_full      = (r_occ == OCC_W'(DEPTH));
  assign w_empty     = (r_occ == '0);
  assign w_ready     = r_run & ~w_full;
  assign w_enq       = io_bus.mdu_valid & w_ready & (io_bus.mdu_rd != 5'd0);
  assign w_busy      = io_bus.pipe_w_en & (io_bus.pipe_rd != 5'd0);
  assign w_head_live = ~w_empty & r_live[r_head];
  assign w_pop_wr    = w_head_live & ~w_busy;
  assign w_pop       = (~w_empty & ~r_live[r_head]) | w_pop_wr;

  always_comb begin
    io_bus.rf_w_en = 1'b0;
    io_bus.rf_rd   = 5'd0;
    io_bus.rf_data = '0;
    if (reset) begin
      if (w_busy) begin
        io_bus.rf_w_en = 1'b1;
        io_bus.rf_rd   = io_bus.pipe_rd;
        io_bus.rf_data = io_bus.pipe_data;
      end else if (w_pop_wr) begin
        io_bus.rf_w_en = 1'b1;
        io_bus.rf_rd   = r_rd[r_head];
        io_bus.rf_data = r_data[r_head];
      end
    end
  end

  // a newer pipeline write to the same rd retires every older queued copy
  always_comb begin
    w_kill = '0;
    w_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i] = w_busy & r_live[i] & (r_rd[i] == io_bus.pipe_rd);
      if (r_live[i] &&
          (((io_bus.chk_rs1 != 5'd0) && (r_rd[i] == io_bus.chk_rs1)) ||
           ((io_bus.chk_rt  != 5'd0) && (r_rd[i] == io_bus.chk_rt))))
        w_pend = 1'b1;
    end
  end

  always_comb begin
    w_live_nxt = r_live & ~w_kill;
    if (w_pop) w_live_nxt[r_head] = 1'b0;
    if (w_enq) w_live_nxt[r_tail] = 1'b1;
  end

  always_comb begin
    w_age_nxt = r_age;
    if (w_pop || w_empty) w_age_nxt = '0;
    else if (w_head_live) w_age_nxt = sat_inc(r_age);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_age  <= '0;
      r_run  <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_live <= w_live_nxt;
      r_age  <= w_age_nxt;
      r_occ  <= r_occ + OCC_W'(w_enq) - OCC_W'(w_pop);
      if (w_pop) r_head <= r_head + PTR_W'(1);
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
    end
  end

  // payload storage is qualified by the live bits and carries no reset
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[r_tail]   <= io_bus.mdu_rd;
      r_data[r_tail] <= io_bus.mdu_data;
    end
  end

  assign io_bus.mdu_ready = w_ready;
  assign io_bus.pend_hit  = w_pend;
  assign io_bus.stall_req = (r_age == AGE_W'(STARVE_LIMIT));
  assign io_bus.occ       = r_occ;

endmodule

// File: tb/tb_ysyx_22041071_wb_arb.sv
// Randomized and directed bench for the write-back arbiter against a
// queue-based behavioural model.
module tb_ysyx_22041071_wb_arb;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int AGE_W = 3;
  localparam int DW    = 64;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int VW    = 73 + OCC_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_22041071_wb_arb_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus();

  ysyx_22041071_wb_arb #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .AGE_W(AGE_W), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .io_bus(bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  int          m_age;
  bit          m_run;
  logic [63:0] m_reg [32];
  logic [63:0] o_reg [32];
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] obs;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  assign obs = {bus.rf_w_en, bus.rf_w_en ? bus.rf_rd : 5'd0, bus.rf_w_en ? bus.rf_data : 64'd0,
                bus.mdu_ready, bus.pend_hit, bus.stall_req, bus.occ};

  function automatic void model_reset();
    mq.delete();
    m_age = 0;
    m_run = 1'b0;
  endfunction

  function automatic void model_expect();
    bit w, pend, rdy, busy;
    logic [4:0] rd;
    logic [63:0] d;
    busy = bus.pipe_w_en && (bus.pipe_rd != 0);
    w = 0; rd = 0; d = 0; pend = 0;
    if (busy) begin
      w = 1; rd = bus.pipe_rd; d = bus.pipe_data;
    end else if (mq.size() > 0 && mq[0].live) begin
      w = 1; rd = mq[0].rd; d = mq[0].data;
    end
    rdy = m_run && (mq.size() < DEPTH);
    foreach (mq[i])
      if (mq[i].live && ((bus.chk_rs1 != 0 && mq[i].rd == bus.chk_rs1) ||
                         (bus.chk_rt  != 0 && mq[i].rd == bus.chk_rt))) pend = 1;
    if (!reset) exp_vec = '0;
    else exp_vec = {w, rd, d, rdy, pend, (m_age >= LIMIT), OCC_W'(mq.size())};
  endfunction

  task automatic apply(input bit pwe, input logic [4:0] prd, input logic [63:0] pd,
                       input bit mv, input logic [4:0] mrd, input logic [63:0] md,
                       input logic [4:0] c1, input logic [4:0] c2);
    bus.pipe_w_en = pwe; bus.pipe_rd = prd; bus.pipe_data = pd;
    bus.mdu_valid = mv;  bus.mdu_rd  = mrd; bus.mdu_data  = md;
    bus.chk_rs1 = c1;    bus.chk_rt  = c2;
    #1;
    model_expect();
  endtask

  task automatic tick();
    bit busy, popped, rdy;
    if (reset && bus.rf_w_en) o_reg[bus.rf_rd] = bus.rf_data;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      model_reset();
    end else begin
      busy = bus.pipe_w_en && (bus.pipe_rd != 0);
      rdy  = m_run && (mq.size() < DEPTH);
      popped = (mq.size() > 0) && (!mq[0].live || !busy);
      if (busy) m_reg[bus.pipe_rd] = bus.pipe_data;
      else if (mq.size() > 0 && mq[0].live) m_reg[mq[0].rd] = mq[0].data;
      if (popped || mq.size() == 0) m_age = 0;
      else if (mq[0].live) m_age++;
      if (popped) void'(mq.pop_front());
      if (busy) foreach (mq[i]) if (mq[i].rd == bus.pipe_rd) mq[i].live = 0;
      if (bus.mdu_valid && rdy && bus.mdu_rd != 0) mq.push_back('{bus.mdu_rd, bus.mdu_data, 1'b1});
      m_run = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    apply(1, 5'd3, 64'h55, 1, 5'd4, 64'h66, 5'd4, 5'd3);
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", obs); end
    tick();
    reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.mdu_ready !== 1'b0 || obs !== exp_vec) begin
      n_fail++; $display("FAIL release_cycle got=%h want=%h", obs, exp_vec);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.mdu_ready !== 1'b1 || obs !== exp_vec) begin
      n_fail++; $display("FAIL ready_after_edge got=%h want=%h", obs, exp_vec);
    end
    tick();
  endtask

  task automatic test_free_port();
    apply(0, 0, 0, 1, 5'd5, 64'hAA, 0, 0);
    n_cmp++;
    if (obs !== exp_vec) begin n_fail++; $display("FAIL free_accept got=%h want=%h", obs, exp_vec); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.rf_w_en !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_data !== 64'hAA || bus.occ !== 2'd1 || obs !== exp_vec) begin
      n_fail++; $display("FAIL free_write got=%h want=%h", obs, exp_vec);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.occ !== 2'd0 || bus.rf_w_en !== 1'b0) begin
      n_fail++; $display("FAIL free_drained got occ=%0d wen=%b want occ=0 wen=0", bus.occ, bus.rf_w_en);
    end
    tick();
  endtask

  task automatic test_pipe_priority();
    apply(0, 0, 0, 1, 5'd6, 64'h66, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1, 5'd7, 64'h700 + i, 0, 0, 0, 0, 0);
      n_cmp++;
      if (bus.rf_rd !== 5'd7 || bus.rf_data !== 64'h700 + i || obs !== exp_vec) begin
        n_fail++; $display("FAIL pipe_priority[%0d] got=%h want=%h", i, obs, exp_vec);
      end
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.rf_w_en !== 1'b1 || bus.rf_rd !== 5'd6 || bus.rf_data !== 64'h66) begin
      n_fail++; $display("FAIL mdu_after_pipe got rd=%0d data=%h want rd=6 data=66", bus.rf_rd, bus.rf_data);
    end
    tick();
  endtask

  task automatic test_starvation();
    apply(0, 0, 0, 1, 5'd8, 64'h88, 0, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      apply(1, 5'd1, 64'(k), 0, 0, 0, 0, 0);
      n_cmp++;
      if (bus.stall_req !== (k >= LIMIT) || obs !== exp_vec) begin
        n_fail++; $display("FAIL starve_wait[%0d] got=%h want=%h", k, obs, exp_vec);
      end
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.rf_rd !== 5'd8 || bus.rf_w_en !== 1'b1 || bus.stall_req !== 1'b1) begin
      n_fail++; $display("FAIL starve_drain got rd=%0d stall=%b want rd=8 stall=1", bus.rf_rd, bus.stall_req);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_release got=%b want=0", bus.stall_req); end
    tick();
  endtask

  task automatic test_full();
    apply(1, 5'd2, 64'h20, 1, 5'd10, 64'hA, 0, 0); tick();
    apply(1, 5'd2, 64'h21, 1, 5'd11, 64'hB, 0, 0); tick();
    apply(1, 5'd2, 64'h22, 1, 5'd12, 64'hC, 0, 0);
    n_cmp++;
    if (bus.mdu_ready !== 1'b0 || bus.occ !== 2'd2 || obs !== exp_vec) begin
      n_fail++; $display("FAIL full_block got=%h want=%h", obs, exp_vec);
    end
    tick();
    apply(0, 0, 0, 1, 5'd12, 64'hC, 0, 0);
    n_cmp++;
    if (bus.mdu_ready !== 1'b0 || bus.rf_rd !== 5'd10 || obs !== exp_vec) begin
      n_fail++; $display("FAIL full_first_pop got=%h want=%h", obs, exp_vec);
    end
    tick();
    apply(0, 0, 0, 1, 5'd12, 64'hC, 0, 0);
    n_cmp++;
    if (bus.mdu_ready !== 1'b1 || bus.rf_rd !== 5'd11 || obs !== exp_vec) begin
      n_fail++; $display("FAIL full_accept_third got=%h want=%h", obs, exp_vec);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL full_drain[%0d] got=%h want=%h", i, obs, exp_vec); end
      tick();
    end
  endtask

  task automatic test_kill();
    apply(1, 5'd3, 64'h33, 1, 5'd9, 64'h11, 5'd9, 0);
    n_cmp++;
    if (bus.pend_hit !== 1'b0) begin n_fail++; $display("FAIL kill_pend_same_cycle got=%b want=0", bus.pend_hit); end
    tick();
    apply(1, 5'd9, 64'h22, 0, 0, 0, 5'd9, 0);
    n_cmp++;
    if (bus.pend_hit !== 1'b1 || obs !== exp_vec) begin
      n_fail++; $display("FAIL kill_pend_before got=%h want=%h", obs, exp_vec);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 5'd9, 0);
    n_cmp++;
    if (bus.pend_hit !== 1'b0 || bus.rf_w_en !== 1'b0 || bus.occ !== 2'd1 || obs !== exp_vec) begin
      n_fail++; $display("FAIL kill_dead_pop got=%h want=%h", obs, exp_vec);
    end
    tick();
    // same-cycle enqueue with matching rd survives the pipeline write
    apply(1, 5'd13, 64'hD0, 1, 5'd13, 64'hD1, 0, 5'd13);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.rf_w_en !== 1'b1 || bus.rf_rd !== 5'd13 || bus.rf_data !== 64'hD1) begin
      n_fail++; $display("FAIL same_cycle_survive got rd=%0d data=%h want rd=13 data=d1", bus.rf_rd, bus.rf_data);
    end
    tick();
  endtask

  task automatic test_rd0();
    apply(0, 0, 0, 1, 5'd0, 64'hEE, 0, 0);
    n_cmp++;
    if (bus.mdu_ready !== 1'b1 || obs !== exp_vec) begin
      n_fail++; $display("FAIL rd0_accept got=%h want=%h", obs, exp_vec);
    end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.occ !== 2'd0 || bus.rf_w_en !== 1'b0) begin
      n_fail++; $display("FAIL rd0_no_enqueue got occ=%0d wen=%b want occ=0 wen=0", bus.occ, bus.rf_w_en);
    end
    tick();
  endtask

  task automatic test_async_reset();
    apply(1, 5'd1, 64'h1, 1, 5'd20, 64'h200, 0, 0); tick();
    apply(1, 5'd1, 64'h2, 1, 5'd21, 64'h210, 0, 0); tick();
    apply(1, 5'd1, 64'h3, 0, 0, 0, 5'd20, 5'd21);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL async_reset_outputs got=%h want=0", obs); end
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 5'd20, 5'd21);
      n_cmp++;
      if (bus.rf_w_en !== 1'b0 || obs !== exp_vec) begin
        n_fail++; $display("FAIL async_reset_discard[%0d] got=%h want=%h", i, obs, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom % 4) != 0, 5'($urandom % 8), {$urandom, $urandom},
            ($urandom % 3) != 0, 5'($urandom % 8), {$urandom, $urandom},
            5'($urandom % 8), 5'($urandom % 8));
      n_cmp++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_vec); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_regfile();
    int bad;
    bad = -1;
    for (int r = 1; r < 32; r++) if (o_reg[r] !== m_reg[r] && bad < 0) bad = r;
    n_cmp++;
    if (bad >= 0) begin
      n_fail++; $display("FAIL regfile x%0d got=%h want=%h", bad, o_reg[bad], m_reg[bad]);
    end
    n_cmp++;
    if (o_reg[9] !== 64'h22) begin n_fail++; $display("FAIL kill_final_x9 got=%h want=22", o_reg[9]); end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin m_reg[r] = '0; o_reg[r] = '0; end
    model_reset();
    reset = 1'b0;
    bus.pipe_w_en = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
    bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
    bus.chk_rs1 = 0; bus.chk_rt = 0;
    @(negedge clk);
    test_reset();
    test_free_port();
    test_pipe_priority();
    test_starvation();
    test_full();
    test_kill();
    test_rd0();
    test_regfile();
    test_async_reset();
    test_random();
    test_regfile();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
